// File: rtl/keypad_scanner.sv
// keypad_scanner: row-strobe matrix scan, per-key debounce, press/release event FIFO.
// Optional auto-repeat of the last pressed key when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scanner #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE = 10,
  localparam int KW = $clog2(ROWS * COLS)
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  output logic [ROWS-1:0] row,
  input  logic [COLS-1:0] col,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [KW-1:0]   ev_code,
  output logic            ev_press,
  output logic            ev_repeat,
  output logic            overflow,
  input  logic            ovf_clr,
  output logic            any_down
);
  localparam int N = ROWS * COLS;
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int CLW = COLS > 1 ? $clog2(COLS) : 1;
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int BW = $clog2(DEBOUNCE + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int EW = KW + 2;
  localparam int PW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
`else
  localparam int EW = KW + 1;
`endif
  typedef enum logic {IDLE, UPD} state_t;
  state_t state_q, state_d;
  logic en_q;
  logic [RW-1:0] r_q, r_d, srow_q, srow_d;
  logic [DW-1:0] d_q, d_d;
  logic [CLW-1:0] c_q, c_d;
  logic [COLS-1:0] samp_q, samp_d;
  logic [N-1:0] stable_q, stable_d;
  logic [N-1:0][BW-1:0] cnt_q, cnt_d;
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] ev_d, head;
  logic overflow_q, overflow_d, any_down_q;
  logic [KW-1:0] key;
  logic last_d, push, pop, wr, full;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [KW-1:0] rk_q, rk_d;
  logic ra_q, ra_d;
  logic [PW-1:0] rc_q, rc_d;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
`endif
  assign row = en_q ? ~(ROWS'(1) << r_q) : '1;
  assign last_d = d_q == DW'(SCAN_DIV - 1);
  assign key = KW'(int'(srow_q) * COLS + int'(c_q));
  assign full = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
  assign ev_valid = wp_q != rp_q;
  assign pop = ev_valid & ev_ready;
  assign wr = push & (~full | pop);
  assign head = mem_q[rp_q[AW-1:0]];
  assign ev_code = ev_valid ? head[KW-1:0] : '0;
  assign ev_press = ev_valid & head[KW];
`ifdef KEYPAD_AUTOREPEAT_EN
  assign ev_repeat = ev_valid & head[KW+1];
`else
  assign ev_repeat = 1'b0;
`endif
  assign overflow = overflow_q;
  assign any_down = any_down_q;
  always_comb begin
    d_d = en_q ? (last_d ? '0 : d_q + 1'b1) : d_q;
    r_d = (en_q && last_d) ? (r_q == RW'(ROWS - 1) ? '0 : r_q + 1'b1) : r_q;
    state_d = state_q;
    c_d = c_q;
    samp_d = samp_q;
    srow_d = srow_q;
    stable_d = stable_q;
    cnt_d = cnt_q;
    push = 1'b0;
    ev_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rk_d = rk_q;
    ra_d = ra_q;
    rc_d = rc_q;
`endif
    if (state_q == IDLE) begin
      if (en_q && last_d) begin
        samp_d = ~col;
        srow_d = r_q;
        c_d = '0;
        state_d = UPD;
      end
    end else begin
      if (samp_q[c_q] == stable_q[key]) cnt_d[key] = '0;
      else if (cnt_q[key] == BW'(DEBOUNCE - 1)) begin
        stable_d[key] = samp_q[c_q];
        cnt_d[key] = '0;
        push = 1'b1;
        ev_d = EW'({samp_q[c_q], key});
      end else cnt_d[key] = cnt_q[key] + 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
      // Frames are counted on the target key's own column slot, once per frame.
      if (push && samp_q[c_q]) begin
        rk_d = key;
        ra_d = 1'b1;
        rc_d = PW'(REPEAT_DELAY);
      end else if (push) ra_d = ra_q & (key != rk_q);
      else if (ra_q && key == rk_q) begin
        push = rc_q == PW'(1);
        rc_d = push ? PW'(REPEAT_RATE) : rc_q - 1'b1;
        ev_d = {2'b11, key};
      end
`endif
      state_d = c_q == CLW'(COLS - 1) ? IDLE : UPD;
      c_d = c_q + 1'b1;
    end
    wp_d = wp_q + {{AW{1'b0}}, wr};
    rp_d = rp_q + {{AW{1'b0}}, pop};
    overflow_d = (push & full & ~pop) | (overflow_q & ~ovf_clr);
  end
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      en_q <= 1'b0;
      r_q <= '0;
      d_q <= '0;
      c_q <= '0;
      samp_q <= '0;
      srow_q <= '0;
      stable_q <= '0;
      cnt_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      overflow_q <= 1'b0;
      any_down_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rk_q <= '0;
      ra_q <= 1'b0;
      rc_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      en_q <= 1'b1;
      r_q <= r_d;
      d_q <= d_d;
      c_q <= c_d;
      samp_q <= samp_d;
      srow_q <= srow_d;
      stable_q <= stable_d;
      cnt_q <= cnt_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      overflow_q <= overflow_d;
      any_down_q <= |stable_q;
`ifdef KEYPAD_AUTOREPEAT_EN
      rk_q <= rk_d;
      ra_q <= ra_d;
      rc_q <= rc_d;
`endif
    end
  end
  always_ff @(posedge sys_clk) if (rst_n && wr) mem_q[wp_q[AW-1:0]] <= ev_d;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad pin model, sample-history debounce reference and event scoreboard.
module tb_keypad_scanner;
  localparam int ROWS = 4, COLS = 4, SD = 8, DEB = 3, FD = 8, RD = 4, RR = 2;
  localparam int FR = ROWS * SD;
  typedef struct packed {logic rep; logic press; logic [3:0] code;} ev_t;
  logic sys_clk = 1'b0, rst_n = 1'b0, ev_ready = 1'b0, ovf_clr = 1'b0;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] col;
  logic ev_valid, ev_press, ev_repeat, overflow, any_down;
  logic [3:0] ev_code;
  logic [15:0] keys = '0;
  int errors = 0, checks = 0, pops_np = 0, pops_rep = 0;
  ev_t exp_q[$], np_log[$];
  ev_t got, want;
  int hist[16];
  bit m_stable[16];
  bit m_ovf = 1'b0;
  int n = 0, m_rr, m_k, mask;
  int rk = 0, rc = 0;
  bit ra = 1'b0;

  keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE(DEB), .FIFO_DEPTH(FD),
                   .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .row(row), .col(col), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_code(ev_code), .ev_press(ev_press), .ev_repeat(ev_repeat), .overflow(overflow),
    .ovf_clr(ovf_clr), .any_down(any_down));

  always #5 sys_clk = ~sys_clk;

  always_comb begin
    col = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row[r] && keys[r*COLS+c]) col[c] = 1'b0;
  end

  function automatic ev_t mk(bit rep, bit press, int code);
    mk = {rep, press, 4'(code)};
  endfunction

  function automatic void m_push(ev_t e);
    if (exp_q.size() >= FD) m_ovf = 1'b1;
    else exp_q.push_back(e);
  endfunction

  // Reference: a key flips once its last DEB row samples all disagree with its accepted state.
  always @(posedge sys_clk) begin
    if (!rst_n) begin
      n = 0;
      m_ovf = 1'b0;
      ra = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 16; i++) begin hist[i] = 0; m_stable[i] = 1'b0; end
    end else begin
      if (n > 0 && n % SD == 0) begin
        m_rr = (n / SD - 1) % ROWS;
        mask = (1 << DEB) - 1;
        for (int c = 0; c < COLS; c++) begin
          m_k = m_rr * COLS + c;
          hist[m_k] = (hist[m_k] << 1) | int'(keys[m_k]);
          if ((hist[m_k] & mask) == (m_stable[m_k] ? 0 : mask)) begin
            m_stable[m_k] = ~m_stable[m_k];
            m_push(mk(1'b0, m_stable[m_k], m_k));
`ifdef KEYPAD_AUTOREPEAT_EN
            if (m_stable[m_k]) begin rk = m_k; ra = 1'b1; rc = 0; end
            else if (m_k == rk) ra = 1'b0;
          end else if (ra && m_k == rk) begin
            rc++;
            if (rc == RD || (rc > RD && (rc - RD) % RR == 0)) m_push(mk(1'b1, 1'b1, m_k));
`endif
          end
        end
      end
      n++;
    end
  end

  always @(negedge sys_clk) begin
    if (rst_n && ev_valid && ev_ready) begin
      got = {ev_repeat, ev_press, ev_code};
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL ev_extra got=%h want=none", got);
      end
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        checks++;
        assert (got === want) else begin
          errors++;
          $error("FAIL ev_order got=%h want=%h", got, want);
        end
      end
      if (got.rep) pops_rep++;
      else begin pops_np++; np_log.push_back(got); end
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int k);
    repeat (k) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_idle(string tag);
    int i = 0;
    while ((exp_q.size() != 0 || ev_valid) && i < 4000) begin tick(1); i++; end
    chk(tag, exp_q.size() + int'(ev_valid), 0);
  endtask

  initial begin
    int p0;
    tick(3);
    @(negedge sys_clk);
    chk("rst_row", row, 4'hF);
    chk("rst_valid", ev_valid, 0);
    chk("rst_code", {ev_code, ev_press, ev_repeat}, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_any", any_down, 0);
    tick(1);
    rst_n = 1'b1;
    @(negedge sys_clk);
    chk("pre_scan_row", row, 4'hF);
    @(negedge sys_clk);
    chk("first_row", row, 4'hE);
    repeat (SD) @(negedge sys_clk);
    chk("second_row", row, 4'hD);
    tick(1);
    ev_ready = 1'b1;
    keys[6] = 1'b1;
    tick(10 * FR);
    chk("pr_any_down", any_down, 1);
    chk("pr_press_cnt", pops_np, 1);
    chk("pr_press_ev", np_log[$], mk(0, 1, 6));
    keys[6] = 1'b0;
    tick(10 * FR);
    chk("pr_any_up", any_down, 0);
    chk("pr_release_cnt", pops_np, 2);
    chk("pr_release_ev", np_log[$], mk(0, 0, 6));
    wait_idle("pr_idle");
    for (int i = 0; i < 5; i++) begin
      keys[13] = 1'b1;
      tick(2 * FR);
      keys[13] = 1'b0;
      tick(FR);
    end
    tick(4 * FR);
    chk("bounce_cnt", pops_np, 2);
    chk("bounce_any", any_down, 0);
    wait_idle("bounce_idle");
    ev_ready = 1'b0;
    foreach (keys[i]) if (i % 3 == 0 && i < 15) begin
      keys[i] = 1'b1;
      tick(5 * FR);
      keys[i] = 1'b0;
      tick(5 * FR);
    end
    chk("ovf_set", overflow, 1);
    chk("ovf_model", overflow, m_ovf);
    chk("ovf_held", exp_q.size(), FD);
    chk("ovf_valid", ev_valid, 1);
    ev_ready = 1'b1;
    wait_idle("ovf_drain");
    chk("ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    m_ovf = 1'b0;
    tick(1);
    ovf_clr = 1'b0;
    tick(1);
    chk("ovf_clr", overflow, 0);
    p0 = pops_np;
    keys[0] = 1'b1;
    keys[3] = 1'b1;
    tick(6 * FR);
    chk("sim_cnt", pops_np - p0, 2);
    chk("sim_first", np_log[$-1], mk(0, 1, 0));
    chk("sim_second", np_log[$], mk(0, 1, 3));
    keys[0] = 1'b0;
    keys[3] = 1'b0;
    tick(6 * FR);
    wait_idle("sim_idle");
    ev_ready = 1'b0;
    keys[9] = 1'b1;
    keys[10] = 1'b1;
    tick(5 * FR);
    keys[10] = 1'b0;
    tick(5 * FR);
    chk("mid_queued", exp_q.size() >= 3, 1);
    chk("mid_valid", ev_valid, 1);
    rst_n = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("mid_rst_valid", ev_valid, 0);
    chk("mid_rst_row", row, 4'hF);
    #1 rst_n = 1'b1;
    ev_ready = 1'b1;
    p0 = pops_np;
    tick(6 * FR);
    chk("mid_fresh_cnt", pops_np - p0, 1);
    chk("mid_fresh_ev", np_log[$], mk(0, 1, 9));
    chk("mid_any", any_down, 1);
    keys[9] = 1'b0;
    tick(6 * FR);
    wait_idle("mid_idle");
`ifdef KEYPAD_AUTOREPEAT_EN
    p0 = pops_rep;
    keys[8] = 1'b1;
    tick(15 * FR);
    chk("rep_seen", pops_rep - p0 >= 3, 1);
    keys[8] = 1'b0;
    tick(6 * FR);
    wait_idle("rep_idle");
`endif
    for (int i = 0; i < 40; i++) begin
      int k = $urandom_range(0, 15);
      keys[k] = ~keys[k];
      tick($urandom_range(1, 3 * FR));
    end
    keys = '0;
    tick(8 * FR);
    wait_idle("rnd_idle");
    chk("rnd_any", any_down, 0);
    chk("rnd_ovf", overflow, m_ovf);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
